ctrl_tx_ll: RTL and testbench

Transmit-side link-layer framer for control FISes: accepts a complete frame from the command engine, buffers it whole, then replays it toward the SATA link layer's transport interface with SOF/EOF framing and source/destination ready handshake. It retries on link-layer discontinue and reports completion or failure. It is the transmit counterpart of the control-FIS receive path and runs entirely in the PHY clock domain; upstream CDC is handled elsewhere.

---
 rtl/ahci_ll_pkg.sv | 21 ++
 rtl/ctrl_tx_buf.sv | 25 ++
 rtl/ctrl_tx_ll.sv | 169 ++++++++++++++++
 tb/tb_ctrl_tx_ll.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahci_ll_pkg.sv
// Shared link-layer definitions: dword width, FIS type codes and the
// control-FIS transmit framer state encoding.
package ahci_ll_pkg;

  localparam int DW_WIDTH = 32;

  localparam logic [7:0] FIS_TYPE_REG_H2D = 8'h27;
  localparam logic [7:0] FIS_TYPE_REG_D2H = 8'h34;
  localparam logic [7:0] FIS_TYPE_DMA_ACT = 8'h39;
  localparam logic [7:0] FIS_TYPE_PIO_SU  = 8'h5F;
  localparam logic [7:0] FIS_TYPE_DEV_BIT = 8'hA1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP,
    ST_DROP
  } tx_state_e;

endpackage

// File: rtl/ctrl_tx_buf.sv
// Frame buffer: simple dual-port RAM with synchronous write and a registered
// read address, so read data lines up with the registered transport strobes.
module ctrl_tx_buf #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] raddr_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    raddr_q <= raddr;
  end

  assign rdata = mem[raddr_q];

endmodule

// File: rtl/ctrl_tx_ll.sv
// Control-FIS transmit framer: buffers a whole frame from the command engine,
// then replays it to the link layer with SOF/EOF framing and discontinue retry.
module ctrl_tx_ll
  import ahci_ll_pkg::*;
#(
  parameter int C_DEPTH_LOG2 = 4,
  parameter int C_RETRY      = 3
) (
  input  logic                phyclk,
  input  logic                phyreset,
  input  logic [DW_WIDTH-1:0] ctrl_tx_data,
  input  logic                ctrl_tx_sof,
  input  logic                ctrl_tx_eof,
  input  logic                ctrl_tx_valid,
  output logic                ctrl_tx_ready,
  output logic                ctrl_tx_busy,
  output logic                ctrl_tx_done,
  output logic                ctrl_tx_err,
  output logic [DW_WIDTH-1:0] trn_td,
  output logic                trn_tsof_n,
  output logic                trn_teof_n,
  output logic                trn_tsrc_rdy_n,
  output logic                trn_tsrc_dsc_n,
  input  logic                trn_tdst_rdy_n,
  input  logic                trn_tdst_dsc_n
);

  localparam int AW = C_DEPTH_LOG2;
  localparam int LW = C_DEPTH_LOG2 + 1;
  localparam int RW = $clog2(C_RETRY) + 1;
  localparam logic [LW-1:0] DEPTH     = LW'(2**C_DEPTH_LOG2);
  localparam logic [RW-1:0] RETRY_MAX = RW'(C_RETRY);

  tx_state_e state, state_n;
  logic [LW-1:0] len, len_n;
  logic [AW-1:0] rd_ptr, rd_ptr_n;
  logic [AW-1:0] last_addr, last_addr_n;
  logic [RW-1:0] attempt, attempt_n, attempt_inc;
  logic          done_n, err_n;
  logic          we;
  logic [AW-1:0] waddr;
  logic          accept, handshake;
  logic [DW_WIDTH-1:0] rd_data;

  assign ctrl_tx_ready  = !phyreset &&
                          (state == ST_IDLE || state == ST_LOAD || state == ST_DROP);
  assign ctrl_tx_busy   = (state != ST_IDLE);
  assign accept         = ctrl_tx_valid && ctrl_tx_ready;
  assign handshake      = !trn_tsrc_rdy_n && !trn_tdst_rdy_n;
  assign last_addr      = AW'(len - LW'(1));
  assign last_addr_n    = AW'(len_n - LW'(1));
  assign attempt_inc    = attempt + RW'(1);
  assign trn_tsrc_dsc_n = 1'b1;
  // Data is forced to zero whenever no beat is offered, which also hides stale RAM.
  assign trn_td         = trn_tsrc_rdy_n ? '0 : rd_data;

  ctrl_tx_buf #(
    .AW (AW),
    .DW (DW_WIDTH)
  ) u_buf (
    .clk   (phyclk),
    .we    (we),
    .waddr (waddr),
    .wdata (ctrl_tx_data),
    .raddr (rd_ptr_n),
    .rdata (rd_data)
  );

  always_comb begin
    state_n   = state;
    len_n     = len;
    rd_ptr_n  = rd_ptr;
    attempt_n = attempt;
    done_n    = 1'b0;
    err_n     = 1'b0;
    we        = 1'b0;
    waddr     = len[AW-1:0];
    case (state)
      ST_IDLE: begin
        if (accept && ctrl_tx_sof) begin
          we        = 1'b1;
          waddr     = '0;
          len_n     = LW'(1);
          rd_ptr_n  = '0;
          attempt_n = '0;
          state_n   = ctrl_tx_eof ? ST_SEND : ST_LOAD;
        end
      end
      ST_LOAD: begin
        // A fresh SOF abandons the partial frame and starts over at word 0.
        if (accept && ctrl_tx_sof) begin
          we        = 1'b1;
          waddr     = '0;
          len_n     = LW'(1);
          rd_ptr_n  = '0;
          attempt_n = '0;
          state_n   = ctrl_tx_eof ? ST_SEND : ST_LOAD;
        end else if (accept && len == DEPTH) begin
          err_n   = 1'b1;
          state_n = ctrl_tx_eof ? ST_IDLE : ST_DROP;
        end else if (accept) begin
          we    = 1'b1;
          len_n = len + LW'(1);
          if (ctrl_tx_eof) begin
            rd_ptr_n  = '0;
            attempt_n = '0;
            state_n   = ST_SEND;
          end
        end
      end
      ST_DROP: begin
        if (accept && ctrl_tx_eof) state_n = ST_IDLE;
      end
      ST_SEND: begin
        // Discontinue wins over a handshake in the same cycle.
        if (!trn_tdst_dsc_n) begin
          if (attempt_inc < RETRY_MAX) begin
            attempt_n = attempt_inc;
            state_n   = ST_GAP;
          end else begin
            attempt_n = '0;
            err_n     = 1'b1;
            state_n   = ST_IDLE;
          end
        end else if (handshake) begin
          if (rd_ptr == last_addr) begin
            attempt_n = '0;
            done_n    = 1'b1;
            state_n   = ST_IDLE;
          end else begin
            rd_ptr_n = rd_ptr + AW'(1);
          end
        end
      end
      ST_GAP: begin
        rd_ptr_n = '0;
        state_n  = ST_SEND;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Transport strobes are registered from the next state so a beat appears
  // the cycle after EOF is accepted and holds while the link layer stalls.
  always_ff @(posedge phyclk) begin
    if (phyreset) begin
      state          <= ST_IDLE;
      len            <= '0;
      rd_ptr         <= '0;
      attempt        <= '0;
      trn_tsrc_rdy_n <= 1'b1;
      trn_tsof_n     <= 1'b1;
      trn_teof_n     <= 1'b1;
      ctrl_tx_done   <= 1'b0;
      ctrl_tx_err    <= 1'b0;
    end else begin
      state          <= state_n;
      len            <= len_n;
      rd_ptr         <= rd_ptr_n;
      attempt        <= attempt_n;
      trn_tsrc_rdy_n <= (state_n != ST_SEND);
      trn_tsof_n     <= !(state_n == ST_SEND && rd_ptr_n == '0);
      trn_teof_n     <= !(state_n == ST_SEND && rd_ptr_n == last_addr_n);
      ctrl_tx_done   <= done_n;
      ctrl_tx_err    <= err_n;
    end
  end

endmodule

// File: tb/tb_ctrl_tx_ll.sv
// Directed bench for ctrl_tx_ll: framing, backpressure, discontinue retry,
// overflow drop and mid-frame reset, each step checked with immediate assertions.
module tb_ctrl_tx_ll;

  logic        phyclk = 1'b0;
  logic        phyreset = 1'b1;
  logic [31:0] ctrl_tx_data = '0;
  logic        ctrl_tx_sof = 1'b0;
  logic        ctrl_tx_eof = 1'b0;
  logic        ctrl_tx_valid = 1'b0;
  logic        ctrl_tx_ready;
  logic        ctrl_tx_busy;
  logic        ctrl_tx_done;
  logic        ctrl_tx_err;
  logic [31:0] trn_td;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tsrc_dsc_n;
  logic        trn_tdst_rdy_n = 1'b0;
  logic        trn_tdst_dsc_n = 1'b1;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] frame [0:31];
  logic [31:0] stall_mask;
  int          beat;
  int          hs;
  int          sof_count;

  ctrl_tx_ll dut (
    .phyclk         (phyclk),
    .phyreset       (phyreset),
    .ctrl_tx_data   (ctrl_tx_data),
    .ctrl_tx_sof    (ctrl_tx_sof),
    .ctrl_tx_eof    (ctrl_tx_eof),
    .ctrl_tx_valid  (ctrl_tx_valid),
    .ctrl_tx_ready  (ctrl_tx_ready),
    .ctrl_tx_busy   (ctrl_tx_busy),
    .ctrl_tx_done   (ctrl_tx_done),
    .ctrl_tx_err    (ctrl_tx_err),
    .trn_td         (trn_td),
    .trn_tsof_n     (trn_tsof_n),
    .trn_teof_n     (trn_teof_n),
    .trn_tsrc_rdy_n (trn_tsrc_rdy_n),
    .trn_tsrc_dsc_n (trn_tsrc_dsc_n),
    .trn_tdst_rdy_n (trn_tdst_rdy_n),
    .trn_tdst_dsc_n (trn_tdst_dsc_n)
  );

  always #5 phyclk = ~phyclk;

  task automatic cyc();
    @(posedge phyclk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_beat(input string tag, input int idx, input int n);
    check_output({tag, "_src"}, 32'(trn_tsrc_rdy_n), 32'd0);
    check_output({tag, "_td"},  trn_td, frame[idx]);
    check_output({tag, "_sof"}, 32'(trn_tsof_n), (idx != 0) ? 32'd1 : 32'd0);
    check_output({tag, "_eof"}, 32'(trn_teof_n), (idx != n - 1) ? 32'd1 : 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_src"},  32'(trn_tsrc_rdy_n), 32'd1);
    check_output({tag, "_sof"},  32'(trn_tsof_n), 32'd1);
    check_output({tag, "_eof"},  32'(trn_teof_n), 32'd1);
    check_output({tag, "_td"},   trn_td, 32'd0);
    check_output({tag, "_dsc"},  32'(trn_tsrc_dsc_n), 32'd1);
    check_output({tag, "_busy"}, 32'(ctrl_tx_busy), 32'd0);
    check_output({tag, "_done"}, 32'(ctrl_tx_done), 32'd0);
    check_output({tag, "_err"},  32'(ctrl_tx_err), 32'd0);
  endtask

  task automatic load_frame(input int n);
    for (int i = 0; i < n; i++) begin
      ctrl_tx_data  = frame[i];
      ctrl_tx_sof   = (i == 0);
      ctrl_tx_eof   = (i == n - 1);
      ctrl_tx_valid = 1'b1;
      cyc();
    end
    ctrl_tx_valid = 1'b0;
    ctrl_tx_sof   = 1'b0;
    ctrl_tx_eof   = 1'b0;
    ctrl_tx_data  = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) cyc();
    check_output("rst_ready", 32'(ctrl_tx_ready), 32'd0);
    check_idle_outputs("rst");
    phyreset = 1'b0;
    #1;
    check_output("post_rst_ready", 32'(ctrl_tx_ready), 32'd1);
    cyc();

    // 5-dword H2D FIS at full throughput
    frame[0] = 32'h00808027; frame[1] = 32'hA0000001; frame[2] = 32'h00000002;
    frame[3] = 32'h00000003; frame[4] = 32'h00000004;
    load_frame(5);
    for (int b = 0; b < 5; b++) begin
      check_beat($sformatf("h2d_b%0d", b), b, 5);
      check_output("h2d_ready_low", 32'(ctrl_tx_ready), 32'd0);
      check_output("h2d_busy", 32'(ctrl_tx_busy), 32'd1);
      check_output("h2d_no_done", 32'(ctrl_tx_done), 32'd0);
      cyc();
    end
    check_output("h2d_done", 32'(ctrl_tx_done), 32'd1);
    check_output("h2d_src_off", 32'(trn_tsrc_rdy_n), 32'd1);
    check_output("h2d_busy_off", 32'(ctrl_tx_busy), 32'd0);
    cyc();
    check_output("h2d_done_pulse", 32'(ctrl_tx_done), 32'd0);

    // Single-dword frame
    frame[0] = 32'h000000A1;
    load_frame(1);
    check_beat("single", 0, 1);
    cyc();
    check_output("single_done", 32'(ctrl_tx_done), 32'd1);
    check_output("single_src_off", 32'(trn_tsrc_rdy_n), 32'd1);
    cyc();

    // 16-dword frame under a fixed stall pattern (about half the cycles stalled)
    for (int i = 0; i < 16; i++) frame[i] = 32'(i) * 32'h01010101 + 32'h27;
    stall_mask = 32'hB2D369CA;
    load_frame(16);
    beat = 0;
    hs = 0;
    for (int c = 0; c < 80 && beat < 16; c++) begin
      trn_tdst_rdy_n = stall_mask[c % 32];
      #1;
      check_beat($sformatf("bp_c%0d", c), beat, 16);
      if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) hs++;
      if (!trn_tdst_rdy_n) beat++;
      cyc();
    end
    trn_tdst_rdy_n = 1'b0;
    check_output("bp_handshakes", 32'(hs), 32'd16);
    check_output("bp_done", 32'(ctrl_tx_done), 32'd1);
    cyc();

    // Discontinue on beat 2 for two attempts, third attempt clean
    frame[0] = 32'h00808027; frame[1] = 32'h11111111; frame[2] = 32'h22222222;
    frame[3] = 32'h33333333; frame[4] = 32'h44444444;
    load_frame(5);
    sof_count = 0;
    for (int a = 0; a < 3; a++) begin
      for (int b = 0; b < 5; b++) begin
        check_beat($sformatf("dsc_a%0d_b%0d", a, b), b, 5);
        if (b == 0 && !trn_tsof_n && !trn_tsrc_rdy_n) sof_count++;
        if (a < 2 && b == 2) begin
          trn_tdst_dsc_n = 1'b0;
          cyc();
          trn_tdst_dsc_n = 1'b1;
          check_output("dsc_gap_src", 32'(trn_tsrc_rdy_n), 32'd1);
          check_output("dsc_gap_err", 32'(ctrl_tx_err), 32'd0);
          check_output("dsc_gap_busy", 32'(ctrl_tx_busy), 32'd1);
          cyc();
          break;
        end
        cyc();
      end
    end
    check_output("dsc_done", 32'(ctrl_tx_done), 32'd1);
    check_output("dsc_sofs", 32'(sof_count), 32'd3);
    cyc();

    // Discontinue on every attempt: retries exhausted
    load_frame(5);
    for (int a = 0; a < 3; a++) begin
      check_beat($sformatf("fail_a%0d", a), 0, 5);
      trn_tdst_dsc_n = 1'b0;
      cyc();
      trn_tdst_dsc_n = 1'b1;
      check_output("fail_src_off", 32'(trn_tsrc_rdy_n), 32'd1);
      check_output("fail_no_done", 32'(ctrl_tx_done), 32'd0);
      if (a < 2) begin
        check_output("fail_gap_err", 32'(ctrl_tx_err), 32'd0);
        cyc();
      end else begin
        check_output("fail_err", 32'(ctrl_tx_err), 32'd1);
        check_output("fail_idle", 32'(ctrl_tx_busy), 32'd0);
      end
    end
    cyc();
    check_output("fail_err_pulse", 32'(ctrl_tx_err), 32'd0);
    check_output("fail_stays_quiet", 32'(trn_tsrc_rdy_n), 32'd1);

    // 20-word frame overflows a 16-dword buffer and is dropped to EOF
    for (int i = 0; i < 20; i++) begin
      ctrl_tx_data  = 32'h10000000 + 32'(i);
      ctrl_tx_sof   = (i == 0);
      ctrl_tx_eof   = (i == 19);
      ctrl_tx_valid = 1'b1;
      cyc();
      check_output($sformatf("ovf_err_w%0d", i), 32'(ctrl_tx_err), (i == 16) ? 32'd1 : 32'd0);
      check_output("ovf_no_send", 32'(trn_tsrc_rdy_n), 32'd1);
      check_output("ovf_ready", 32'(ctrl_tx_ready), 32'd1);
    end
    ctrl_tx_valid = 1'b0;
    ctrl_tx_sof   = 1'b0;
    ctrl_tx_eof   = 1'b0;
    check_output("ovf_idle", 32'(ctrl_tx_busy), 32'd0);
    cyc();
    check_output("ovf_still_quiet", 32'(trn_tsrc_rdy_n), 32'd1);
    check_output("ovf_no_done", 32'(ctrl_tx_done), 32'd0);

    // Reset in the middle of a transmission, then a clean frame
    frame[0] = 32'h00808027; frame[1] = 32'h55555555; frame[2] = 32'h66666666;
    frame[3] = 32'h77777777; frame[4] = 32'h88888888;
    load_frame(5);
    check_beat("mid_b0", 0, 5);
    cyc();
    check_beat("mid_b1", 1, 5);
    cyc();
    phyreset = 1'b1;
    #1;
    check_output("mid_rst_ready", 32'(ctrl_tx_ready), 32'd0);
    cyc();
    check_idle_outputs("mid_rst");
    phyreset = 1'b0;
    cyc();
    check_output("mid_rst_quiet_done", 32'(ctrl_tx_done), 32'd0);
    frame[0] = 32'h000000B7;
    load_frame(1);
    check_beat("after_rst", 0, 1);
    cyc();
    check_output("after_rst_done", 32'(ctrl_tx_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
